sbox_permute_serial: RTL and testbench
======================================

Name: sbox_permute_serial

Overview:
- Inverse-width companion to the round function's 32->48 expansion stage.
- Takes the 48-bit value (E(R) XOR subkey) and reduces it back to 32 bits.
- Reduction is the eight DES S-box substitutions (FIPS 46-3 S1..S8) followed by the 32-bit P permutation.
- S-boxes are evaluated serially, SBOX_PER_CYCLE per clock, to trade area for latency.
- Valid/ready handshake on both sides, so the round controller can stall it.

Parameters:
- SBOX_PER_CYCLE, default 1: S-box lookups per clock. Legal values are 1, 2, 4, 8; any other value is an elaboration error. K = 8/SBOX_PER_CYCLE is the number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  x_in valid
- in_ready  output  1  block can accept x_in
- x_in  input  48  E(R) XOR subkey; DES bit n at index [48-n]
- out_valid  output  1  f_out valid
- out_ready  input  1  downstream accepts f_out
- f_out  output  32  P(S1..S8 output); DES bit n at index [32-n]

Behaviour:
- Bit mapping:
  - S1 consumes x_in[47:42], S2 consumes x_in[41:36], ..., S8 consumes x_in[5:0].
  - For each 6-bit group b1..b6 (b1 = MSB): row = {b1,b6}, column = {b2,b3,b4,b5}.
  - S1 output lands in S-result bits [31:28], ..., S8 output in [3:0].
  - f_out = standard P table applied to the S-result, same MSB = bit 1 convention.
- State machine: IDLE, BUSY, DONE.
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=1, out_valid=0, f_out=0, counter=0, internal shift and accumulate registers=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge: load x_in into the 48-bit shift register, clear the 32-bit accumulator, counter=0, go to BUSY.
- BUSY:
  - in_ready=0; in_valid and x_in are ignored.
  - Each edge: look up the top 6*SBOX_PER_CYCLE bits. Shift the shift register left by 6*SBOX_PER_CYCLE. Shift the accumulator left by 4*SBOX_PER_CYCLE and insert the new nibbles (first S-box in the higher nibble). Counter increments.
  - On the edge where counter==K-1: register f_out = P(final accumulator) and go to DONE.
- DONE:
  - out_valid=1; f_out is held stable while out_ready=0.
  - On out_valid&out_ready at an edge: go to IDLE, out_valid=0.
  - f_out keeps its last value until the next completion; it is only meaningful while out_valid=1.
  - in_ready=0 in DONE. There is no same-cycle accept on completion.
- Latency: out_valid rises K edges after the accepting edge (8 for SBOX_PER_CYCLE=1, 1 for 8).
- Minimum issue interval: K+2 cycles.
- Counter width is 3 bits. It is never compared beyond K-1, so it does not wrap within a block.
- Reset mid-BUSY or mid-DONE: outputs return to reset values immediately (asynchronous). A pending result is discarded; no partial result is ever presented.
- in_valid deasserted with no handshake in IDLE: no state change.
- The lookup is purely combinational from registered state. No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Reset: hold rst_n=0 mid-run, assert rst_n at a non-clock time -> in_ready=1, out_valid=0, f_out=0 immediately, without waiting for a clock edge.
2. FIPS walkthrough round 1, SBOX_PER_CYCLE=1: x_in=0x6117BA866527 -> S-result 0x5C82B597, f_out=0x234AA9BB, out_valid rising exactly 8 edges after accept.
3. All-zero input, SBOX_PER_CYCLE=8: x_in=0 -> S-result 0xEFA72C4D, f_out=0xD8D8DBBC, out_valid rising 1 edge after accept. Repeat with SBOX_PER_CYCLE=2 and 4 and check latency 4 and 2.
4. Backpressure: complete vector 2 with out_ready=0 for 5 cycles -> out_valid stays 1, f_out stays stable at 0x234AA9BB, in_ready=0. Then raise out_ready -> one transfer, IDLE on the next cycle.
5. Ignored input: toggle in_valid with x_in=0 during BUSY of vector 2 -> result still 0x234AA9BB, and exactly one output transfer.
6. Reset mid-BUSY: pulse rst_n low at counter=3, then issue x_in=0 -> no stale output; the single result is 0xD8D8DBBC after 8 edges.

Source files
------------

// File: rtl/sbox_permute_serial.sv
// sbox_permute_serial
//   Reduces the 48-bit round value (E(R) XOR subkey) back to 32 bits.
//   It applies the eight DES S-boxes S1..S8 and then the P permutation.
//   The S-boxes are evaluated serially, SBOX_PER_CYCLE per clock, so a block
//   takes K = 8/SBOX_PER_CYCLE compute cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x_in is valid
//   in_ready   block can accept x_in (only while idle)
//   x_in       48-bit E(R) XOR subkey, DES bit n at index [48-n]
//   out_valid  f_out is valid, held until out_ready
//   out_ready  downstream accepts f_out
//   f_out      P(S1..S8 output), DES bit n at index [32-n]
module sbox_permute_serial #(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);

  localparam int K  = 8 / SBOX_PER_CYCLE;
  localparam int GW = 6 * SBOX_PER_CYCLE;
  localparam int NW = 4 * SBOX_PER_CYCLE;
  localparam logic [2:0] LAST = 3'(K - 1);

  // Only power-of-two lane counts divide the eight S-boxes evenly.
  if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
        SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
    $error("sbox_permute_serial: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  // Each S-box is 4 rows x 16 columns of nibbles, row 0 column 0 at the MSB.
  localparam logic [255:0] S1 = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
  localparam logic [255:0] S2 = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
  localparam logic [255:0] S3 = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
  localparam logic [255:0] S4 = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
  localparam logic [255:0] S5 = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
  localparam logic [255:0] S6 = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
  localparam logic [255:0] S7 = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
  localparam logic [255:0] S8 = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  // P table: output bit i+1 takes S-result bit P_TBL[i] (bit 1 = MSB).
  localparam int P_TBL [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                 1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9,
                                19, 13, 30,  6, 22, 11,  4, 25};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [47:0]       shreg;
  logic [31:0]       acc;
  logic [31:0]       acc_next;
  logic [2:0]        cnt;
  logic [NW-1:0]     nibbles;

  // Row is {b1,b6}, column is {b2..b5}; flattened index row*16+col.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] sel,
                                             input logic [5:0] b);
    logic [255:0] tbl;
    logic [5:0]   pos;
    case (sel)
      3'd0:    tbl = S1;
      3'd1:    tbl = S2;
      3'd2:    tbl = S3;
      3'd3:    tbl = S4;
      3'd4:    tbl = S5;
      3'd5:    tbl = S6;
      3'd6:    tbl = S7;
      default: tbl = S8;
    endcase
    pos = {b[5], b[0], b[4:1]};
    return tbl[4*(63 - int'(pos)) +: 4];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      p[31-i] = s[32 - P_TBL[i]];
    end
    return p;
  endfunction

  // Look up the S-boxes sitting at the top of the shift register this cycle
  // and form the accumulator value with their nibbles appended; the first
  // S-box of the group lands in the higher nibble.
  always_comb begin
    nibbles = '0;
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
      nibbles[NW-4-4*j +: 4] = sbox_lookup(3'(int'(cnt) * SBOX_PER_CYCLE + j),
                                           shreg[47-6*j -: 6]);
    end
    acc_next = (acc << NW) | 32'(nibbles);
  end

  // Datapath and state register. f_out is only written on the final compute
  // cycle so it stays stable through DONE and afterwards until the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      f_out <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= x_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          shreg <= shreg << GW;
          acc   <= acc_next;
          cnt   <= cnt + 3'd1;
          if (cnt == LAST) begin
            f_out <= p_perm(acc_next);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and handshake outputs; both ready and valid decode the
  // registered state only, so neither has a path from the opposite input.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sbox_permute_serial.sv
// tb_sbox_permute_serial
//   Directed bench for sbox_permute_serial. Four instances cover
//   SBOX_PER_CYCLE = 1, 2, 4, 8 and share clock and reset; each has its own
//   handshake signals indexed 0..3.
module tb_sbox_permute_serial;

  localparam logic [47:0] FIPS_X = 48'h6117BA866527;
  localparam logic [31:0] FIPS_F = 32'h234AA9BB;
  localparam logic [31:0] ZERO_F = 32'hD8D8DBBC;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] x_in      [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] f_out     [4];

  int compared;
  int mismatched;
  int lat;
  int stale;
  logic [31:0] f_hold;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sbox_permute_serial #(.SBOX_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .x_in      (x_in[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .f_out     (f_out[gi])
    );
  end

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string tag, input logic [47:0] got,
                             input logic [47:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Offer one block to instance i (inputs change 1 time unit after an edge),
  // then count edges until out_valid rises. With toggle set, in_valid is
  // wiggled with x_in=0 while the block is busy. Latency is bounded.
  task automatic applyStimulus(input int i, input logic [47:0] x,
                               input bit toggle, output int edges);
    checkOutput("accept_in_ready", 48'(in_ready[i]), 48'd1);
    in_valid[i] = 1'b1;
    x_in[i]     = x;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    x_in[i]     = '0;
    edges = 0;
    while (!out_valid[i] && edges < 20) begin
      if (toggle) begin
        in_valid[i] = ~in_valid[i];
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid[i] = 1'b0;
  endtask

  // Take the pending result and confirm exactly one transfer happened.
  task automatic drainOutput(input int i);
    int extra;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    checkOutput("xfer_out_valid", 48'(out_valid[i]), 48'd0);
    checkOutput("xfer_in_ready", 48'(in_ready[i]), 48'd1);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid[i]) extra++;
    end
    checkOutput("single_xfer", 48'(extra), 48'd0);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      x_in[i]      = '0;
    end

    // Reset values before any clock edge.
    #3;
    for (int i = 0; i < 4; i++) begin
      checkOutput("rst_in_ready", 48'(in_ready[i]), 48'd1);
      checkOutput("rst_out_valid", 48'(out_valid[i]), 48'd0);
      checkOutput("rst_f_out", 48'(f_out[i]), 48'd0);
    end
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS round 1, one S-box per cycle, with in_valid toggled while busy
    // and the result backpressured for five cycles.
    $display("[TB] FIPS vector, SBOX_PER_CYCLE=1, backpressure");
    applyStimulus(0, FIPS_X, 1'b1, lat);
    checkOutput("fips1_latency", 48'(lat), 48'd8);
    checkOutput("fips1_f_out", 48'(f_out[0]), 48'(FIPS_F));
    f_hold = f_out[0];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 48'(out_valid[0]), 48'd1);
      checkOutput("bp_f_stable", 48'(f_out[0]), 48'(f_hold));
      checkOutput("bp_in_ready", 48'(in_ready[0]), 48'd0);
    end
    drainOutput(0);

    // All-zero input at the wider lane counts.
    $display("[TB] zero vector, SBOX_PER_CYCLE=8/2/4");
    applyStimulus(3, 48'd0, 1'b0, lat);
    checkOutput("zero8_latency", 48'(lat), 48'd1);
    checkOutput("zero8_f_out", 48'(f_out[3]), 48'(ZERO_F));
    checkOutput("done8_in_ready", 48'(in_ready[3]), 48'd0);
    drainOutput(3);
    applyStimulus(1, 48'd0, 1'b0, lat);
    checkOutput("zero2_latency", 48'(lat), 48'd4);
    checkOutput("zero2_f_out", 48'(f_out[1]), 48'(ZERO_F));
    drainOutput(1);
    applyStimulus(2, 48'd0, 1'b0, lat);
    checkOutput("zero4_latency", 48'(lat), 48'd2);
    checkOutput("zero4_f_out", 48'(f_out[2]), 48'(ZERO_F));
    drainOutput(2);

    // FIPS vector through the parallel instances as well.
    applyStimulus(1, FIPS_X, 1'b0, lat);
    checkOutput("fips2_f_out", 48'(f_out[1]), 48'(FIPS_F));
    drainOutput(1);
    applyStimulus(3, FIPS_X, 1'b0, lat);
    checkOutput("fips8_f_out", 48'(f_out[3]), 48'(FIPS_F));
    drainOutput(3);

    // Reset while a result is pending: outputs clear without a clock edge.
    $display("[TB] reset during DONE");
    applyStimulus(0, FIPS_X, 1'b0, lat);
    checkOutput("pre_rst_valid", 48'(out_valid[0]), 48'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_in_ready", 48'(in_ready[0]), 48'd1);
    checkOutput("async_rst_out_valid", 48'(out_valid[0]), 48'd0);
    checkOutput("async_rst_f_out", 48'(f_out[0]), 48'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_out_valid", 48'(out_valid[0]), 48'd0);

    // Reset while busy at counter 3, then a fresh block.
    $display("[TB] reset during BUSY");
    in_valid[0] = 1'b1;
    x_in[0]     = FIPS_X;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    x_in[0]     = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("busy_rst_in_ready", 48'(in_ready[0]), 48'd1);
    checkOutput("busy_rst_out_valid", 48'(out_valid[0]), 48'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid[0]) stale++;
    end
    checkOutput("no_stale_output", 48'(stale), 48'd0);
    applyStimulus(0, 48'd0, 1'b0, lat);
    checkOutput("after_rst_latency", 48'(lat), 48'd8);
    checkOutput("after_rst_f_out", 48'(f_out[0]), 48'(ZERO_F));
    drainOutput(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
